// File: rtl/mcs4_bus_master.sv
// CPU-side sequencer for the MCS-4 multiplexed nibble bus.
// It produces sync and the A/M/X phase cycle, fetches an instruction, and runs one X-phase transfer.
module mcs4_bus_master #(
  parameter logic [3:0] IO_GROUP = 4'hE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [11:0] pc_in,
  output logic [7:0]  instr_out,
  output logic        instr_valid,
  input  logic [1:0]  x_cmd,
  input  logic [3:0]  x_data,
  output logic [3:0]  rd_data,
  output logic        rd_valid,
  input  logic        clr_io,
  output logic        sync,
  output logic        cm_rom,
  output logic        cl_rom,
  input  logic [3:0]  dbus_in,
  output logic [3:0]  dbus_out
);

  typedef enum logic [3:0] {
    ST_A1   = 4'd0,
    ST_A2   = 4'd1,
    ST_A3   = 4'd2,
    ST_M1   = 4'd3,
    ST_M2   = 4'd4,
    ST_X1   = 4'd5,
    ST_X2   = 4'd6,
    ST_X3   = 4'd7,
    ST_IDLE = 4'd8
  } state_t;

  localparam logic [1:0] XC_SRC   = 2'd1;
  localparam logic [1:0] XC_WRITE = 2'd2;
  localparam logic [1:0] XC_READ  = 2'd3;

  state_t      r_state;
  logic [11:0] r_pc;
  logic [7:0]  r_instr;
  logic        r_instr_valid;
  logic [1:0]  r_x_cmd;
  logic [3:0]  r_x_data;
  logic [3:0]  r_rd_data;
  logic        r_rd_valid;
  logic        r_clr_pend;
  logic        r_cl_rom;

  logic        w_sync;
  logic        w_cm_rom;
  logic [3:0]  w_dbus_out;

  // sync is high exactly in the cycle whose closing edge enters A1
  assign w_sync = run && (r_state == ST_IDLE || r_state == ST_X3);

  always_comb begin
    w_dbus_out = 4'h0;
    w_cm_rom   = 1'b0;
    case (r_state)
      ST_A1: w_dbus_out = r_pc[3:0];
      ST_A2: w_dbus_out = r_pc[7:4];
      ST_A3: w_dbus_out = r_pc[11:8];
      ST_M2: w_cm_rom   = (r_instr[7:4] == IO_GROUP);
      ST_X2: begin
        if (r_x_cmd == XC_SRC || r_x_cmd == XC_WRITE) w_dbus_out = r_x_data;
        w_cm_rom = (r_x_cmd == XC_SRC);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= 12'h000;
      r_instr       <= 8'h00;
      r_instr_valid <= 1'b0;
      r_x_cmd       <= 2'd0;
      r_x_data      <= 4'h0;
      r_rd_data     <= 4'h0;
      r_rd_valid    <= 1'b0;
      r_clr_pend    <= 1'b0;
      r_cl_rom      <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      r_rd_valid    <= 1'b0;
      if (w_sync) r_pc <= pc_in;
      // a clear request waits for the next A1; a new one during that A1 re-arms it
      r_cl_rom   <= r_clr_pend && w_sync;
      r_clr_pend <= clr_io || (r_clr_pend && !w_sync);
      case (r_state)
        ST_IDLE: if (run) r_state <= ST_A1;
        ST_X3:   r_state <= run ? ST_A1 : ST_IDLE;
        default: r_state <= state_t'(r_state + 4'd1);
      endcase
      case (r_state)
        ST_M1: r_instr[7:4] <= dbus_in;
        ST_M2: begin
          r_instr[3:0]  <= dbus_in;
          r_instr_valid <= 1'b1;
        end
        ST_X1: begin
          r_x_cmd  <= x_cmd;
          r_x_data <= x_data;
        end
        ST_X2: if (r_x_cmd == XC_READ) begin
          r_rd_data  <= dbus_in;
          r_rd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sync        = w_sync;
  assign cm_rom      = w_cm_rom;
  assign cl_rom      = r_cl_rom;
  assign dbus_out    = w_dbus_out;
  assign instr_out   = r_instr;
  assign instr_valid = r_instr_valid;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;

endmodule

// File: tb/tb_mcs4_bus_master.sv
// Scoreboard bench: the driver plays the core and the ROM/RAM responders and queues one expectation per instruction cycle.
// A sync-triggered monitor checks every phase of each cycle against the expectation it pops.
module tb_mcs4_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [11:0] pc_in;
  logic [7:0]  instr_out;
  logic        instr_valid;
  logic [1:0]  x_cmd;
  logic [3:0]  x_data;
  logic [3:0]  rd_data;
  logic        rd_valid;
  logic        clr_io;
  logic        sync;
  logic        cm_rom;
  logic        cl_rom;
  logic [3:0]  dbus_in;
  logic [3:0]  dbus_out;

  always #5 clk = ~clk;

  mcs4_bus_master #(.IO_GROUP(4'hE)) dut (
    .clk(clk), .rst(rst), .run(run), .pc_in(pc_in),
    .instr_out(instr_out), .instr_valid(instr_valid),
    .x_cmd(x_cmd), .x_data(x_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_io(clr_io), .sync(sync), .cm_rom(cm_rom), .cl_rom(cl_rom),
    .dbus_in(dbus_in), .dbus_out(dbus_out)
  );

  typedef struct packed {
    logic [11:0] pc;
    logic [7:0]  instr;
    logic [1:0]  cmd;
    logic [3:0]  xd;
    logic [3:0]  rdn;
    logic        keep_run;
    logic        clr;
  } txn_t;

  txn_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // model state carried between instruction cycles
  logic [7:0] m_instr = 8'h00;
  logic [3:0] m_rd    = 4'h0;
  bit         m_cl    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic check_cycle();
    txn_t       t;
    logic [3:0] e_bus;
    logic       e_cm;
    logic [7:0] e_instr;
    logic [3:0] e_rd;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_sync: sync=1 with no cycle queued at %0t", $time);
      @(negedge clk);
      return;
    end
    t = q.pop_front();
    for (int p = 1; p <= 8; p++) begin
      @(negedge clk);
      case (p)
        1: e_bus = t.pc[3:0];
        2: e_bus = t.pc[7:4];
        3: e_bus = t.pc[11:8];
        7: e_bus = (t.cmd == 2'd1 || t.cmd == 2'd2) ? t.xd : 4'h0;
        default: e_bus = 4'h0;
      endcase
      e_cm    = (p == 5) ? (t.instr[7:4] == 4'hE) : (p == 7) ? (t.cmd == 2'd1) : 1'b0;
      e_instr = (p <= 4) ? m_instr : (p == 5) ? {t.instr[7:4], m_instr[3:0]} : t.instr;
      e_rd    = (p == 8 && t.cmd == 2'd3) ? t.rdn : m_rd;
      chk($sformatf("dbus_out ph%0d", p), dbus_out, e_bus);
      chk($sformatf("cm_rom ph%0d", p), cm_rom, e_cm);
      chk($sformatf("instr_valid ph%0d", p), instr_valid, p == 6);
      chk($sformatf("instr_out ph%0d", p), instr_out, e_instr);
      chk($sformatf("rd_valid ph%0d", p), rd_valid, (p == 8 && t.cmd == 2'd3));
      chk($sformatf("rd_data ph%0d", p), rd_data, e_rd);
      chk($sformatf("sync ph%0d", p), sync, (p == 8) ? t.keep_run : 1'b0);
      chk($sformatf("cl_rom ph%0d", p), cl_rom, (p == 1) ? m_cl : 1'b0);
      if (p == 1) m_cl = 1'b0;
      if (p == 5 && t.clr) m_cl = 1'b1;
    end
    m_instr = t.instr;
    if (t.cmd == 2'd3) m_rd = t.rdn;
    $display("cycle pc=%03h instr=%02h cmd=%0d xd=%0h rdn=%0h run=%0d clr=%0d checks=%0d errors=%0d",
             t.pc, t.instr, t.cmd, t.xd, t.rdn, t.keep_run, t.clr, checks, errors);
  endtask

  initial begin
    wait (mon_en);
    @(negedge clk);
    forever begin
      if (sync === 1'b1) check_cycle();
      else @(negedge clk);
    end
  end

  // Called in the cycle that should carry sync; returns in X3.
  task automatic run_cycle(input txn_t t);
    q.push_back(t);
    run   = 1'b1;
    pc_in = t.pc;
    @(posedge clk); #1;
    pc_in   = 12'($urandom);
    dbus_in = 4'h0;
    x_cmd   = 2'($urandom);
    @(posedge clk); #1;
    pc_in = 12'($urandom);
    @(posedge clk); #1;
    @(posedge clk); #1;
    dbus_in = t.instr[7:4];
    if (!t.keep_run) run = 1'b0;
    @(posedge clk); #1;
    dbus_in = t.instr[3:0];
    clr_io  = t.clr;
    @(posedge clk); #1;
    dbus_in = 4'h0;
    clr_io  = 1'b0;
    x_cmd   = t.cmd;
    x_data  = t.xd;
    @(posedge clk); #1;
    x_cmd   = 2'($urandom);
    x_data  = 4'($urandom);
    dbus_in = (t.cmd == 2'd3) ? t.rdn : 4'h0;
    @(posedge clk); #1;
    dbus_in = 4'h0;
  endtask

  task automatic idle_after(input txn_t t);
    if (!t.keep_run) repeat (1 + $urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    txn_t t;
    rst = 1'b1; run = 1'b0; pc_in = 12'h000; x_cmd = 2'd0; x_data = 4'h0;
    clr_io = 1'b0; dbus_in = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset sync", sync, 0);
    chk("reset cm_rom", cm_rom, 0);
    chk("reset cl_rom", cl_rom, 0);
    chk("reset dbus_out", dbus_out, 0);
    chk("reset instr_out", instr_out, 0);
    chk("reset rd_valid", rd_valid, 0);

    // start a fetch, arm a clear in M2, then reset during X1
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b1; pc_in = 12'h123; dbus_in = 4'h5;
    @(negedge clk);
    chk("first sync", sync, 1);
    repeat (5) begin
      @(posedge clk); #1;
    end
    clr_io = 1'b1;
    @(posedge clk); #1;
    clr_io = 1'b0;
    @(negedge clk);
    chk("pre-reset instr_valid", instr_valid, 1);
    chk("pre-reset instr_out", instr_out, 8'h55);
    rst = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst sync", sync, 0);
    chk("midrst cm_rom", cm_rom, 0);
    chk("midrst cl_rom", cl_rom, 0);
    chk("midrst instr_valid", instr_valid, 0);
    chk("midrst rd_valid", rd_valid, 0);
    chk("midrst dbus_out", dbus_out, 0);
    chk("midrst rd_data", rd_data, 0);
    chk("midrst instr_out", instr_out, 0);
    @(posedge clk); #1;
    rst = 1'b0; dbus_in = 4'h0;
    repeat (2) begin
      @(posedge clk); #1;
    end

    mon_en = 1'b1;
    t = '{pc: 12'h2A5, instr: 8'h3C, cmd: 2'd0, xd: 4'h0, rdn: 4'h0, keep_run: 1'b1, clr: 1'b0};
    run_cycle(t);
    t = '{pc: 12'h3F0, instr: 8'hE2, cmd: 2'd2, xd: 4'h9, rdn: 4'h0, keep_run: 1'b1, clr: 1'b1};
    run_cycle(t);
    t = '{pc: 12'h001, instr: 8'h21, cmd: 2'd1, xd: 4'h3, rdn: 4'h0, keep_run: 1'b1, clr: 1'b0};
    run_cycle(t);
    t = '{pc: 12'h002, instr: 8'hE9, cmd: 2'd3, xd: 4'hF, rdn: 4'h6, keep_run: 1'b0, clr: 1'b0};
    run_cycle(t);
    idle_after(t);
    for (int i = 0; i < 40; i++) begin
      t.pc       = 12'($urandom);
      t.instr    = 8'($urandom);
      t.cmd      = 2'($urandom);
      t.xd       = 4'($urandom);
      t.rdn      = 4'($urandom);
      t.keep_run = ($urandom_range(0, 7) != 0);
      t.clr      = ($urandom_range(0, 5) == 0);
      run_cycle(t);
      idle_after(t);
    end
    t = '{pc: 12'hFFF, instr: 8'hE1, cmd: 2'd3, xd: 4'h0, rdn: 4'hA, keep_run: 1'b0, clr: 1'b0};
    run_cycle(t);
    repeat (4) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("queue drained", q.size(), 0);
    chk("idle sync", sync, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcs4_bus_master.md
# mcs4_bus_master

Initiator end of the MCS-4 4-bit multiplexed bus, i.e. the CPU-side bus sequencer that the 4001 ROM and 4002 RAM responders listen to.
- Generates `sync` and the eight-phase instruction cycle.
- Drives the 12-bit fetch address during A1–A3 and captures the 8-bit instruction during M1–M2.
- Asserts `cm_rom` for the I/O group and SRC.
- Executes one X-phase transfer per cycle: chip select, port write or port read.

It sits between the CPU core's fetch/decode logic and the shared bus fabric. The bus fabric ORs all `dbus_out` nibbles into every agent's `dbus_in`.

## Interface
Parameters:
- `IO_GROUP`, 4'hE, OPR nibble that marks an I/O-group instruction and causes `cm_rom` at M2.

Ports:
- `clk`  in  1  single system clock
- `rst`  in  1  synchronous, active-high reset
- `run`  in  1  allow a new instruction cycle to start
- `pc_in`  in  12  fetch address; sampled on the sync cycle
- `instr_out`  out  8  fetched instruction {OPR, OPA}
- `instr_valid`  out  1  one-cycle pulse during X1
- `x_cmd`  in  2  X-phase op: 0 NONE, 1 SRC, 2 WRITE, 3 READ; sampled in X1
- `x_data`  in  4  chip select (SRC) or write data (WRITE); sampled in X1
- `rd_data`  out  4  nibble read at X2
- `rd_valid`  out  1  one-cycle pulse during X3 after a READ
- `clr_io`  in  1  request to clear responder I/O outputs
- `sync`  out  1  cycle-start marker to responders
- `cm_rom`  out  1  ROM command line
- `cl_rom`  out  1  ROM clear line
- `dbus_in`  in  4  OR-combined bus nibble
- `dbus_out`  out  4  nibble this agent drives

## Operation
- State: `IDLE` plus phases A1, A2, A3, M1, M2, X1, X2, X3 (encoded 0..7), matching the `mcs4::instr_cyc_t` order.
- `sync` = `run` && (state == IDLE || state == X3).
- Phase transitions:
  - IDLE → A1 when `run` is high; otherwise stay in IDLE.
  - A1 → … → X3 unconditionally.
  - X3 → A1 if `run` is high, else → IDLE.
- Address capture: on a clock edge with `sync` high, `pc_q` <= `pc_in`.
- `dbus_out` by phase:
  - A1 = `pc_q[3:0]`, A2 = `pc_q[7:4]`, A3 = `pc_q[11:8]`.
  - M1, M2, X1, X3 = 0.
  - X2 = `x_data_q` if `x_cmd_q` is SRC or WRITE, else 0.
  - IDLE = 0.
- Instruction capture:
  - End of M1: `instr_out[7:4]` <= `dbus_in`.
  - End of M2: `instr_out[3:0]` <= `dbus_in`.
  - `instr_out` holds until the next M1.
- `instr_valid` is a registered pulse, high exactly in X1. The core decodes combinationally and presents `x_cmd` and `x_data` during X1. Both are registered at the end of X1 into `x_cmd_q` and `x_data_q`.
- `cm_rom` is high:
  - in M2 when `instr_out[7:4]` == `IO_GROUP`;
  - in X2 when `x_cmd_q` == SRC;
  - never otherwise.
- READ: end of X2 `rd_data` <= `dbus_in`; `rd_valid` is high during X3 only. `rd_data` holds until the next READ.
- `cl_rom`: a `clr_io` pulse is latched as pending. `cl_rom` is driven high for exactly one cycle at the next A1, then pending clears. A `clr_io` arriving in the same cycle that `cl_rom` is high re-arms pending.
- `x_cmd` values outside X1 are ignored.

## Timing
- Reset values:
  - state IDLE.
  - `sync`, `cm_rom`, `cl_rom`, `instr_valid`, `rd_valid` = 0.
  - `dbus_out`, `rd_data` = 0; `instr_out` = 8'h00.
  - `pc_q`, `x_cmd_q`, `x_data_q`, clear-pending = 0.
- First cycle after reset release with `run` high: `sync` = 1. The A1 address nibble appears one cycle later.
- Full instruction cycle is 8 clocks; with `run` held high, `sync` pulses every 8 clocks.
- Latencies:
  - `pc_in` → A1 bus: 1 clock after the sync edge.
  - M2 bus → `instr_valid`: next cycle.
  - X2 bus → `rd_valid`: next cycle.
- Reset mid-cycle (any phase) → IDLE next edge, all outputs at reset values. Responders realign at the next `sync`.
- `run` dropping mid-cycle: the current cycle completes. `sync` stays low at X3 and the state goes to IDLE.
- `pc_in` changes outside the sync cycle have no effect.

## Test plan
- Reset, then `run`=1 with `pc_in`=12'h2A5:
  - `sync` first cycle;
  - `dbus_out` = 5, A, 2 on the following three cycles;
  - `sync` again 8 cycles later.
- ROM model returns 8'h3C at M1/M2 → `instr_out`=8'h3C, `instr_valid` high only in X1, `cm_rom` low in M2.
- Fetch 8'hE2 (WRR) with `x_cmd`=WRITE, `x_data`=4'h9 in X1 → `cm_rom` high in M2, `dbus_out`=9 in X2, `cm_rom` low in X2.
- SRC with `x_data`=4'h3, then a READ cycle with responder driving 4'h6 at X2:
  - SRC cycle: `cm_rom` high in X2, `dbus_out`=3.
  - READ cycle: `rd_data`=6, `rd_valid` high in X3 only.
- `run` dropped during M1 → cycle finishes, no `sync` at X3, IDLE. Re-raise `run` → `sync` next cycle.
- Assert `rst` during X1, and separately pulse `clr_io` during M2:
  - `rst`: all outputs zero next cycle.
  - `clr_io`: `cl_rom` high for one cycle at the next A1 only.
